// File: rtl/baccarat_pkg.sv
// Shared types and the dealer third-card rule for the Punto Banco match controller.
package baccarat_pkg;

  localparam int unsigned SCORE_W = 4;

  typedef enum logic [3:0] {
    IDLE, CLEAR, DP1, DD1, DP2, DD2, CHK5, DP3, CHK6, DD3, DECIDE, SHOW, DONE
  } state_t;

  typedef enum logic [1:0] {
    PWIN, DWIN, TIE
  } result_t;

  // Dealer draws a third card based on his two-card score and the player's third card.
  function automatic logic dealer_draws(input logic [SCORE_W-1:0] dscore,
                                        input logic [SCORE_W-1:0] pcard3);
    logic draw;
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (pcard3 != 4'd8);
      4'd4:             draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      4'd5:             draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      4'd6:             draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

endpackage

// File: rtl/baccarat_tally.sv
// Match tallies and round counter, plus the early-finish majority compare.
module baccarat_tally
  import baccarat_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             slow_clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc_pwin,
  input  logic             inc_dwin,
  input  logic             inc_tie,
  input  logic             inc_round,
  output logic [CNT_W-1:0] pwins,
  output logic [CNT_W-1:0] dwins,
  output logic [CNT_W-1:0] ties,
  output logic [CNT_W-1:0] round_idx,
  output logic             majority_c
);

  localparam int unsigned MAJ = NUM_ROUNDS / 2;

  // Counters must hold NUM_ROUNDS without wrapping.
  if (NUM_ROUNDS < 1 || (2 ** CNT_W) <= NUM_ROUNDS) begin : g_bad_width
    $error("baccarat_tally: CNT_W too small for NUM_ROUNDS, or NUM_ROUNDS < 1");
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      pwins     <= '0;
      dwins     <= '0;
      ties      <= '0;
      round_idx <= '0;
    end else if (clear) begin
      pwins     <= '0;
      dwins     <= '0;
      ties      <= '0;
      round_idx <= '0;
    end else begin
      if (inc_pwin)  pwins     <= pwins + CNT_W'(1);
      if (inc_dwin)  dwins     <= dwins + CNT_W'(1);
      if (inc_tie)   ties      <= ties + CNT_W'(1);
      if (inc_round) round_idx <= round_idx + CNT_W'(1);
    end
  end

  assign majority_c = (pwins > CNT_W'(MAJ)) || (dwins > CNT_W'(MAJ));

endmodule

// File: rtl/baccarat_match_ctrl.sv
// Punto Banco match controller: deals each round under card_valid handshake, tallies, shows results.
module baccarat_match_ctrl
  import baccarat_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS       = 8,
  parameter int unsigned CNT_W            = 4,
  parameter int unsigned HOLD_CYCLES      = 4,
  parameter bit          STOP_ON_MAJORITY = 1'b0
) (
  input  logic               slow_clock,
  input  logic               reset,
  input  logic               start,
  input  logic               card_valid,
  input  logic [SCORE_W-1:0] pscore,
  input  logic [SCORE_W-1:0] dscore,
  input  logic [SCORE_W-1:0] pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               clear_hand,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic [CNT_W-1:0]   pwins,
  output logic [CNT_W-1:0]   dwins,
  output logic [CNT_W-1:0]   ties,
  output logic [CNT_W-1:0]   round_idx,
  output logic               busy,
  output logic               match_done
);

  localparam int unsigned HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam int unsigned HOLD_W   = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;

  state_t              state_q, state_d;
  result_t             result_q, result_d;
  logic [HOLD_W-1:0]   hold_q;
  logic                hold_last;
  logic                tally_clear, inc_pwin, inc_dwin, inc_tie, inc_round;
  logic                majority_c;

  baccarat_tally #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .CNT_W      (CNT_W)
  ) u_tally (
    .slow_clock (slow_clock),
    .reset      (reset),
    .clear      (tally_clear),
    .inc_pwin   (inc_pwin),
    .inc_dwin   (inc_dwin),
    .inc_tie    (inc_tie),
    .inc_round  (inc_round),
    .pwins      (pwins),
    .dwins      (dwins),
    .ties       (ties),
    .round_idx  (round_idx),
    .majority_c (majority_c)
  );

  assign hold_last = (hold_q == HOLD_W'(HOLD_EFF - 1));

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= PWIN;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hold_q   <= (state_q == SHOW && !hold_last) ? hold_q + HOLD_W'(1) : '0;
    end
  end

  always_comb begin
    state_d          = state_q;
    result_d         = result_q;
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    clear_hand       = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    match_done       = 1'b0;
    tally_clear      = 1'b0;
    inc_pwin         = 1'b0;
    inc_dwin         = 1'b0;
    inc_tie          = 1'b0;
    inc_round        = 1'b0;
    busy             = (state_q != IDLE) && (state_q != DONE);

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          match_done       = 1'b1;
          player_win_light = (pwins >= dwins);
          dealer_win_light = (dwins >= pwins);
        end
        if (start) begin
          tally_clear = 1'b1;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        clear_hand = 1'b1;
        state_d    = DP1;
      end
      DP1: begin
        load_pcard1 = card_valid;
        if (card_valid) state_d = DD1;
      end
      DD1: begin
        load_dcard1 = card_valid;
        if (card_valid) state_d = DP2;
      end
      DP2: begin
        load_pcard2 = card_valid;
        if (card_valid) state_d = DD2;
      end
      DD2: begin
        load_dcard2 = card_valid;
        if (card_valid) state_d = CHK5;
      end
      CHK5: begin
        if (pscore >= 4'd8 || dscore >= 4'd8) state_d = DECIDE;
        else if (pscore <= 4'd5)              state_d = DP3;
        else if (dscore <= 4'd5)              state_d = DD3;
        else                                  state_d = DECIDE;
      end
      DP3: begin
        load_pcard3 = card_valid;
        if (card_valid) state_d = CHK6;
      end
      CHK6: begin
        state_d = dealer_draws(dscore, pcard3) ? DD3 : DECIDE;
      end
      DD3: begin
        load_dcard3 = card_valid;
        if (card_valid) state_d = DECIDE;
      end
      DECIDE: begin
        if (pscore > dscore) begin
          result_d = PWIN;
          inc_pwin = 1'b1;
        end else if (dscore > pscore) begin
          result_d = DWIN;
          inc_dwin = 1'b1;
        end else begin
          result_d = TIE;
          inc_tie  = 1'b1;
        end
        state_d = SHOW;
      end
      SHOW: begin
        player_win_light = (result_q != DWIN);
        dealer_win_light = (result_q != PWIN);
        if (hold_last) begin
          if (round_idx == CNT_W'(NUM_ROUNDS - 1) || (STOP_ON_MAJORITY && majority_c)) begin
            state_d = DONE;
          end else begin
            inc_round = 1'b1;
            state_d   = CLEAR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_baccarat_match_ctrl.sv
// Directed table-driven bench for baccarat_match_ctrl (default build plus a short majority build).
module tb_baccarat_match_ctrl;

  typedef struct {
    logic [3:0] ps;
    logic [3:0] ds;
    logic [3:0] c3;
    int         exp_p3;
    int         exp_d3;
    int         exp_lt;   // {player_light, dealer_light}
  } vec_t;

  logic       slow_clock = 1'b0;
  logic       reset      = 1'b1;
  logic       card_valid;
  logic [3:0] pscore, dscore, pcard3;
  logic       start [2];
  logic       lp1 [2], lp2 [2], lp3 [2], ld1 [2], ld2 [2], ld3 [2];
  logic       clr [2], plt [2], dlt [2], bsy [2], dne [2];
  logic [3:0] pw [2], dw [2], tw [2], ri [2];

  int   nvec  = 0;
  int   nmiss = 0;
  int   sel   = 0;
  vec_t tbl [8];

  always #5 slow_clock = ~slow_clock;

  baccarat_match_ctrl u0 (
    .slow_clock(slow_clock), .reset(reset), .start(start[0]), .card_valid(card_valid),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(lp1[0]), .load_pcard2(lp2[0]), .load_pcard3(lp3[0]),
    .load_dcard1(ld1[0]), .load_dcard2(ld2[0]), .load_dcard3(ld3[0]),
    .clear_hand(clr[0]), .player_win_light(plt[0]), .dealer_win_light(dlt[0]),
    .pwins(pw[0]), .dwins(dw[0]), .ties(tw[0]), .round_idx(ri[0]),
    .busy(bsy[0]), .match_done(dne[0])
  );

  baccarat_match_ctrl #(
    .NUM_ROUNDS(5), .CNT_W(4), .HOLD_CYCLES(0), .STOP_ON_MAJORITY(1'b1)
  ) u1 (
    .slow_clock(slow_clock), .reset(reset), .start(start[1]), .card_valid(card_valid),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(lp1[1]), .load_pcard2(lp2[1]), .load_pcard3(lp3[1]),
    .load_dcard1(ld1[1]), .load_dcard2(ld2[1]), .load_dcard3(ld3[1]),
    .clear_hand(clr[1]), .player_win_light(plt[1]), .dealer_win_light(dlt[1]),
    .pwins(pw[1]), .dwins(dw[1]), .ties(tw[1]), .round_idx(ri[1]),
    .busy(bsy[1]), .match_done(dne[1])
  );

  task automatic step();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmiss++;
      $display("FAIL %s (dut %0d): got %0d, expected %0d at %0t", nm, sel, act, exp, $time);
    end
  endtask

  function automatic int strobes();
    return int'(lp1[sel]) + int'(lp2[sel]) + int'(lp3[sel])
         + int'(ld1[sel]) + int'(ld2[sel]) + int'(ld3[sel]);
  endfunction

  function automatic int lights();
    return int'({plt[sel], dlt[sel]});
  endfunction

  function automatic int outs();
    return int'({lp1[sel], lp2[sel], lp3[sel], ld1[sel], ld2[sel], ld3[sel], clr[sel],
                 plt[sel], dlt[sel], bsy[sel], dne[sel], pw[sel], dw[sel], tw[sel], ri[sel]});
  endfunction

  // Called on the CLEAR cycle; returns on the cycle after SHOW.
  task automatic run_round(input vec_t v, input int hold);
    int tot = 0, n3p = 0, n3d = 0, multi = 0, n = 0, guard = 0;
    pscore = v.ps;
    dscore = v.ds;
    pcard3 = v.c3;
    step();
    while (lights() == 0 && guard < 40) begin
      tot += strobes();
      n3p += int'(lp3[sel]);
      n3d += int'(ld3[sel]);
      if (strobes() > 1) multi++;
      guard++;
      step();
    end
    chk("round_timeout", int'(guard < 40), 1);
    chk("strobe_total", tot, 4 + v.exp_p3 + v.exp_d3);
    chk("load_pcard3_cnt", n3p, v.exp_p3);
    chk("load_dcard3_cnt", n3d, v.exp_d3);
    chk("strobe_onehot", multi, 0);
    while (lights() != 0 && !dne[sel] && n < 20) begin
      chk("show_lights", lights(), v.exp_lt);
      n++;
      step();
    end
    chk("show_hold_len", n, hold);
  endtask

  task automatic run_match(input int nplay, input int hold);
    int ep = 0, ed = 0, et = 0;
    start[sel] = 1'b1;
    step();
    start[sel] = 1'b0;
    chk("start_clear_hand", int'(clr[sel]), 1);
    chk("start_busy", int'(bsy[sel]), 1);
    chk("start_tally_zero", int'(pw[sel]) + int'(dw[sel]) + int'(tw[sel]), 0);
    for (int r = 0; r < nplay; r++) begin
      chk("round_idx", int'(ri[sel]), r);
      run_round(tbl[r], hold);
      if (tbl[r].exp_lt == 2)      ep++;
      else if (tbl[r].exp_lt == 1) ed++;
      else                         et++;
      chk("pwins", int'(pw[sel]), ep);
      chk("dwins", int'(dw[sel]), ed);
      chk("ties", int'(tw[sel]), et);
      if (r < nplay - 1) chk("next_clear_hand", int'(clr[sel]), 1);
      else               chk("match_done", int'(dne[sel]), 1);
    end
    chk("done_busy", int'(bsy[sel]), 0);
    chk("done_lights", lights(), (ep > ed) ? 2 : (ed > ep) ? 1 : 3);
    chk("done_round_idx", int'(ri[sel]), nplay - 1);
    step();
    chk("done_held", int'(dne[sel]), 1);
  endtask

  task automatic fill_all(input logic [3:0] ps, input logic [3:0] ds, input int lt);
    for (int i = 0; i < 8; i++) tbl[i] = '{ps, ds, 4'd0, 0, 0, lt};
  endtask

  initial begin
    int g;
    start[0] = 1'b0;
    start[1] = 1'b0;
    card_valid = 1'b1;
    pscore = '0;
    dscore = '0;
    pcard3 = '0;
    repeat (3) @(posedge slow_clock);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      chk("reset_outputs", outs(), 0);
    end
    reset = 1'b0;
    sel = 0;
    step();

    // Player naturals every round.
    fill_all(4'd8, 4'd3, 2);
    run_match(8, 4);

    // Mixed tableau: third-card rules on both sides.
    tbl[0] = '{4'd4, 4'd3, 4'd8, 1, 0, 2};
    tbl[1] = '{4'd4, 4'd6, 4'd7, 1, 1, 1};
    tbl[2] = '{4'd6, 4'd5, 4'd0, 0, 1, 2};
    tbl[3] = '{4'd7, 4'd7, 4'd0, 0, 0, 3};
    tbl[4] = '{4'd2, 4'd9, 4'd0, 0, 0, 1};
    tbl[5] = '{4'd5, 4'd4, 4'd1, 1, 0, 2};
    tbl[6] = '{4'd0, 4'd5, 4'd5, 1, 1, 1};
    tbl[7] = '{4'd3, 4'd2, 4'd0, 1, 1, 2};
    run_match(8, 4);

    // Handshake stall in DD1, start ignored while busy, then reset in DP3.
    pscore = 4'd4;
    dscore = 4'd3;
    pcard3 = 4'd8;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("stall_clear_hand", int'(clr[0]), 1);
    step();
    chk("dp1_load", int'(lp1[0]), 1);
    step();
    card_valid = 1'b0;
    start[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_strobes", strobes(), 0);
      chk("stall_no_clear", int'(clr[0]), 0);
      step();
    end
    start[0] = 1'b0;
    card_valid = 1'b1;
    #1;
    chk("dd1_load", int'(ld1[0]), 1);
    chk("dd1_only_strobe", strobes(), 1);
    step();
    chk("dp2_load", int'(lp2[0]), 1);
    g = 0;
    while (!lp3[0] && g < 10) begin
      g++;
      step();
    end
    chk("dp3_reached", int'(lp3[0]), 1);
    reset = 1'b1;
    #1;
    chk("reset_mid_round", outs(), 0);
    step();
    reset = 1'b0;
    step();
    chk("idle_busy", int'(bsy[0]), 0);
    chk("idle_done", int'(dne[0]), 0);
    chk("idle_outputs", outs(), 0);

    // All ties.
    fill_all(4'd7, 4'd7, 3);
    run_match(8, 4);

    // Majority early stop, HOLD_CYCLES=0 behaves as one cycle.
    sel = 1;
    fill_all(4'd8, 4'd3, 2);
    run_match(3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
